// File: rtl/mdu_pkg.sv
// Shared types and constants for the E-stage multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // {hi, lo}: hi occupies bits [63:32]
  typedef logic [63:0] mdu_res_t;

endpackage

// File: rtl/mdu_if.sv
// E-stage operand/control bundle between the pipeline and the multiply/divide unit.
// The cancel signal exists only when MDU_CANCEL_EN is defined.
interface mdu_if;
  logic [31:0] w1;
  logic [31:0] w2;
  logic        op_valid;
  logic [2:0]  md_op;
  logic        hilo_sel;
`ifdef MDU_CANCEL_EN
  logic        cancel;
`endif
  logic [31:0] hilo_out;
  logic        busy;
  logic        stall_req;

  modport master (
    output w1, w2, op_valid, md_op, hilo_sel,
`ifdef MDU_CANCEL_EN
    output cancel,
`endif
    input  hilo_out, busy, stall_req
  );

  modport slave (
    input  w1, w2, op_valid, md_op, hilo_sel,
`ifdef MDU_CANCEL_EN
    input  cancel,
`endif
    output hilo_out, busy, stall_req
  );
endinterface

// File: rtl/mdu_calc.sv
// Combinational signed/unsigned multiply and divide producing {hi, lo} plus a divide-by-zero flag.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output mdu_res_t    res,
  output logic        div0
);

  logic signed [63:0] a_sx, b_sx, prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        mag_a, mag_b, den_s, den_u;
  logic [31:0]        q_mag, r_mag, q_u, r_u;
  logic [31:0]        q_s, r_s;

  assign a_sx   = {{32{a[31]}}, a};
  assign b_sx   = {{32{b[31]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a} * {32'd0, b};

  assign div0 = (b == 32'd0);

  // Signed divide on magnitudes: avoids the 0x80000000 / -1 overflow corner entirely
  assign mag_a = a[31] ? (32'd0 - a) : a;
  assign mag_b = b[31] ? (32'd0 - b) : b;
  assign den_s = div0 ? 32'd1 : mag_b;
  assign den_u = div0 ? 32'd1 : b;
  assign q_mag = mag_a / den_s;
  assign r_mag = mag_a % den_s;
  assign q_u   = a / den_u;
  assign r_u   = a % den_u;
  assign q_s   = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
  assign r_s   = a[31] ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    res = '0;
    case (op)
      MD_MULT:  res = mdu_res_t'(prod_s);
      MD_MULTU: res = prod_u;
      MD_DIV:   res = {r_s, q_s};
      MD_DIVU:  res = {r_u, q_u};
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers, sitting beside the ALU in E.
// Optional MDU_CANCEL_EN adds an E-stage flush input that aborts an in-flight op.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave mdu
);

  localparam logic [15:0] MUL_N = 16'(MULT_CYCLES);
  localparam logic [15:0] DIV_N = 16'(DIV_CYCLES);

  mdu_state_e  state, state_n;
  logic [15:0] cnt;
  logic        busy_q;
  mdu_res_t    tmp;
  logic        tmp_div0;
  logic [31:0] hi, lo;

  mdu_res_t    calc_res;
  logic        calc_div0;
  logic        cancel_w;
  logic        is_mul, is_div, go_mul, go_div, finish, abort, mt_hi, mt_lo;

`ifdef MDU_CANCEL_EN
  assign cancel_w = mdu.cancel;
`else
  assign cancel_w = 1'b0;
`endif

  mdu_calc u_calc (
    .op   (mdu.md_op),
    .a    (mdu.w1),
    .b    (mdu.w2),
    .res  (calc_res),
    .div0 (calc_div0)
  );

  assign is_mul = mdu.op_valid && (mdu.md_op == MD_MULT || mdu.md_op == MD_MULTU);
  assign is_div = mdu.op_valid && (mdu.md_op == MD_DIV  || mdu.md_op == MD_DIVU);

  always_comb begin
    state_n = state;
    go_mul  = 1'b0;
    go_div  = 1'b0;
    finish  = 1'b0;
    abort   = 1'b0;
    mt_hi   = 1'b0;
    mt_lo   = 1'b0;
    case (state)
      MDU_IDLE: begin
        mt_hi = mdu.op_valid && (mdu.md_op == MD_MTHI);
        mt_lo = mdu.op_valid && (mdu.md_op == MD_MTLO);
        if (is_mul && !cancel_w) begin
          go_mul  = 1'b1;
          state_n = MDU_MUL;
        end else if (is_div && !cancel_w) begin
          go_div  = 1'b1;
          state_n = MDU_DIV;
        end
      end
      MDU_MUL, MDU_DIV: begin
        // Flush wins over a completion landing on the same edge
        if (cancel_w) begin
          abort   = 1'b1;
          state_n = MDU_IDLE;
        end else if (cnt == ((state == MDU_MUL) ? MUL_N : DIV_N)) begin
          finish  = 1'b1;
          state_n = MDU_IDLE;
        end
      end
      default: state_n = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= MDU_IDLE;
      cnt      <= '0;
      busy_q   <= 1'b0;
      tmp      <= '0;
      tmp_div0 <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state <= state_n;
      if (go_mul || go_div) begin
        tmp      <= calc_res;
        tmp_div0 <= go_div && calc_div0;
        cnt      <= 16'd1;
        busy_q   <= 1'b1;
      end else if (finish || abort) begin
        cnt    <= '0;
        busy_q <= 1'b0;
        if (finish && !tmp_div0) begin
          hi <= tmp[63:32];
          lo <= tmp[31:0];
        end
      end else if (busy_q) begin
        cnt <= cnt + 16'd1;
      end
      if (mt_hi) hi <= mdu.w1;
      if (mt_lo) lo <= mdu.w1;
    end
  end

  assign mdu.busy      = busy_q;
  assign mdu.hilo_out  = mdu.hilo_sel ? hi : lo;
  assign mdu.stall_req = busy_q || (mdu.op_valid && (mdu.md_op <= 3'd3));

endmodule

// File: tb/tb_mdu_unit.sv
// Directed and randomized checks of mdu_unit against an arithmetic HI/LO model.
module tb_mdu_unit;

  localparam int MULN = 5;
  localparam int DIVN = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  int   busy_starts = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_if bus();

  mdu_unit #(.MULT_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
    .clk   (clk),
    .reset (rst_n),
    .mdu   (bus)
  );

  always #5 clk = ~clk;

  // The hazard unit must never let a start reach E while the unit is occupied
  always @(posedge clk)
    if (rst_n && bus.busy && bus.op_valid && bus.md_op <= 3'd3) busy_starts++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint p;
    logic [63:0] u;
    sa = a;
    sb = b;
    case (op)
      3'd0: begin p = longint'(sa) * longint'(sb); u = p; m_hi = u[63:32]; m_lo = u[31:0]; end
      3'd1: begin u = 64'(a) * 64'(b); m_hi = u[63:32]; m_lo = u[31:0]; end
      3'd2: if (b != 0) begin
              if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = a; m_hi = 0; end
              else begin m_lo = sa / sb; m_hi = sa % sb; end
            end
      3'd3: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    @(negedge clk);
    bus.hilo_sel = 1'b0;
    #1 check({tag, "_lo"}, bus.hilo_out, elo);
    bus.hilo_sel = 1'b1;
    #1 check({tag, "_hi"}, bus.hilo_out, ehi);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n, exp_n;
    logic [31:0] old_lo;
    old_lo = m_lo;
    exp_n = (op <= 3'd1) ? MULN : (op <= 3'd3) ? DIVN : 0;
    @(negedge clk);
    bus.op_valid = 1'b1; bus.md_op = op; bus.w1 = a; bus.w2 = b; bus.hilo_sel = 1'b0;
    #1 check({tag, "_stall"}, {31'd0, bus.stall_req}, (op <= 3'd3) ? 32'd1 : 32'd0);
    @(posedge clk);
    #1 bus.op_valid = 1'b0; bus.md_op = 3'd7;
    n = 0;
    repeat (200) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
      if (n == 1) check({tag, "_noleak"}, bus.hilo_out, old_lo);
    end
    check({tag, "_cycles"}, n, exp_n);
    model_op(op, a, b);
  endtask

  initial begin
    int n;
    logic [2:0] op;
    logic [31:0] a, b;
    bus.w1 = '0; bus.w2 = '0; bus.op_valid = 1'b0; bus.md_op = 3'd7; bus.hilo_sel = 1'b0;
`ifdef MDU_CANCEL_EN
    bus.cancel = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_stall", {31'd0, bus.stall_req}, 32'd0);
    check_hilo("rst", 32'd0, 32'd0);

    run_op("mthi", 3'd4, 32'hA5A5_A5A5, 32'd0);
    check("mthi_busy", {31'd0, bus.busy}, 32'd0);
    check_hilo("mthi", 32'hA5A5_A5A5, 32'd0);

    run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3);
    check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2);
    check_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2);
    check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu0", 3'd3, 32'd7, 32'd0);
    check_hilo("divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check_hilo("divovf", 32'd0, 32'h8000_0000);

    // MTLO arriving while a MULT is in flight must be dropped
    @(negedge clk);
    bus.op_valid = 1'b1; bus.md_op = 3'd0; bus.w1 = 32'd5; bus.w2 = 32'd7;
    @(posedge clk);
    #1 bus.md_op = 3'd5; bus.w1 = 32'h1234;
    @(posedge clk);
    #1 bus.op_valid = 1'b0; bus.md_op = 3'd7;
    n = 0;
    repeat (200) begin @(negedge clk); if (!bus.busy) break; n++; end
    check("mtlo_busy_cycles", n, MULN - 1);
    model_op(3'd0, 32'd5, 32'd7);
    check_hilo("mtlo_busy", 32'd0, 32'd35);

    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 5));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 300)));
      if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
      run_op("rnd", op, a, b);
      check_hilo("rnd", m_hi, m_lo);
    end

`ifdef MDU_CANCEL_EN
    // Cancel in cycle 2 of a MULT keeps the previous HI/LO
    @(negedge clk);
    bus.op_valid = 1'b1; bus.md_op = 3'd0; bus.w1 = 32'd9; bus.w2 = 32'd9;
    @(posedge clk);
    #1 bus.op_valid = 1'b0; bus.md_op = 3'd7;
    @(posedge clk);
    #1 bus.cancel = 1'b1;
    @(posedge clk);
    #1 bus.cancel = 1'b0;
    check("cancel_busy", {31'd0, bus.busy}, 32'd0);
    check_hilo("cancel", m_hi, m_lo);
    // Cancel coinciding with a start suppresses the start
    @(negedge clk);
    bus.op_valid = 1'b1; bus.md_op = 3'd2; bus.w1 = 32'd100; bus.w2 = 32'd3; bus.cancel = 1'b1;
    @(posedge clk);
    #1 bus.op_valid = 1'b0; bus.md_op = 3'd7; bus.cancel = 1'b0;
    check("cancel_start_busy", {31'd0, bus.busy}, 32'd0);
    check_hilo("cancel_start", m_hi, m_lo);
`endif

    // Asynchronous reset in cycle 3 of a DIV
    @(negedge clk);
    bus.op_valid = 1'b1; bus.md_op = 3'd2; bus.w1 = 32'd100; bus.w2 = 32'd3;
    @(posedge clk);
    #1 bus.op_valid = 1'b0; bus.md_op = 3'd7;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("rstmid_busy", {31'd0, bus.busy}, 32'd0);
    bus.hilo_sel = 1'b0;
    #1 check("rstmid_lo", bus.hilo_out, 32'd0);
    bus.hilo_sel = 1'b1;
    #1 check("rstmid_hi", bus.hilo_out, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op("postrst", 3'd3, 32'd100, 32'd3);
    check_hilo("postrst", 32'd1, 32'd33);

    check("no_start_while_busy", busy_starts, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
